// File: rtl/div.sv
// Sequential 32-bit radix-2 restoring divider, signed or unsigned.
// Start/done handshake; one quotient bit per cycle, sign fix-up in a final cycle.
module div (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        is_signed,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        busy,
   output logic        done,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        div_by_zero
);

   localparam int unsigned RegBus = 32;

   typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

   state_e              state_q, state_d;
   logic [4:0]          cnt_q;
   logic [RegBus-1:0]   rem_q;
   logic [RegBus-1:0]   quo_q;
   logic [RegBus-1:0]   dsr_q;
   logic [RegBus-1:0]   dvd_q;
   logic                neg_quo_q;
   logic                neg_rem_q;
   logic                zero_q;

   logic                dvd_neg, dsr_neg;
   logic [RegBus-1:0]   dvd_abs, dsr_abs;
   logic [RegBus:0]     part_rem;
   logic [RegBus:0]     diff;
   logic                borrow;
   logic [RegBus-1:0]   rem_next;
   logic [RegBus-1:0]   q_fix, r_fix;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StCalc;
         StCalc:  if (cnt_q == 5'd31) state_d = StFix;
         StFix:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy = (state_q != StIdle);
   end

   // Operand magnitudes, one restoring step, and sign fix-up
   always_comb begin
      dvd_neg  = is_signed & dividend[RegBus-1];
      dsr_neg  = is_signed & divisor[RegBus-1];
      dvd_abs  = dvd_neg ? -dividend : dividend;
      dsr_abs  = dsr_neg ? -divisor : divisor;
      // 33-bit partial remainder; its MSB after the subtract is the borrow
      part_rem = {rem_q, quo_q[RegBus-1]};
      diff     = part_rem - {1'b0, dsr_q};
      borrow   = diff[RegBus];
      rem_next = borrow ? part_rem[RegBus-1:0] : diff[RegBus-1:0];
      q_fix    = zero_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
      r_fix    = zero_q ? dvd_q : (neg_rem_q ? -rem_q : rem_q);
   end

   // Datapath and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dsr_q       <= '0;
         dvd_q       <= '0;
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         zero_q      <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  cnt_q     <= '0;
                  rem_q     <= '0;
                  quo_q     <= dvd_abs;
                  dsr_q     <= dsr_abs;
                  dvd_q     <= dividend;
                  neg_quo_q <= dvd_neg ^ dsr_neg;
                  neg_rem_q <= dvd_neg;
                  zero_q    <= (divisor == '0);
               end
            end
            StCalc: begin
               // Dividend bits shift out of quo_q as quotient bits shift in
               rem_q <= rem_next;
               quo_q <= {quo_q[RegBus-2:0], ~borrow};
               cnt_q <= cnt_q + 5'd1;
            end
            StFix: begin
               done        <= 1'b1;
               quotient    <= q_fix;
               remainder   <= r_fix;
               div_by_zero <= zero_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for div: hand-computed vectors, latency,
// busy-start rejection, back-to-back issue and reset abort.
module tb_div;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        is_signed;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] last_q = '0;
   logic [31:0] last_r = '0;
   int dones;

   div dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .is_signed   (is_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Issue one divide at the current negedge and wait (bounded) for done.
   // inject_at>0 pulses a stray start at that cycle of the busy window.
   task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eq,
                          input logic [31:0] er, input logic ez, input int inject_at);
      int lat;
      start     = 1'b1;
      is_signed = sgn;
      dividend  = a;
      divisor   = b;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         start     = (lat == inject_at);
         dividend  = $urandom;
         divisor   = $urandom;
         is_signed = (lat == inject_at) ? ~sgn : sgn;
         if (lat == 1) begin
            chk({tag, " busy"}, {31'b0, busy}, 32'd1);
            chk({tag, " held q"}, quotient, last_q);
         end
      end while (!done && lat < 40);
      chk({tag, " latency"}, lat, 34);
      chk({tag, " busy@done"}, {31'b0, busy}, 32'd0);
      chk({tag, " quotient"}, quotient, eq);
      chk({tag, " remainder"}, remainder, er);
      chk({tag, " dbz"}, {31'b0, div_by_zero}, {31'b0, ez});
      last_q = eq;
      last_r = er;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(negedge clk);
      chk("rst busy", {31'b0, busy}, 32'd0);
      chk("rst done", {31'b0, done}, 32'd0);
      chk("rst q", quotient, 32'd0);
      chk("rst r", remainder, 32'd0);
      chk("rst dbz", {31'b0, div_by_zero}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      run_div("u100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0);
      @(negedge clk);
      chk("done pulse 1 cycle", {31'b0, done}, 32'd0);
      chk("q held idle", quotient, 32'd14);
      run_div("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 0);
      run_div("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 0);
      run_div("s-100/7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 0);
      run_div("uFFFF/16", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0, 0);
      run_div("s-1/16", 1'b1, 32'hFFFF_FFFF, 32'h10, 32'd0, 32'hFFFF_FFFF, 1'b0, 0);
      run_div("u/0", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 0);
      run_div("s/0", 1'b1, 32'h8000_0001, 32'd0, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1, 0);
      run_div("s ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 0);

      // Stray start at +5 must be ignored; no second done follows
      run_div("ign", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 5);
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) dones++;
      end
      chk("ign extra done", dones, 0);

      // Back-to-back: second start issued in the done cycle of the first
      run_div("b2b 1", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0, 0);
      run_div("b2b 2", 1'b0, 32'h1234_5678, 32'h100, 32'h0012_3456, 32'h78, 1'b0, 0);

      // Reset at +20 aborts with no done pulse
      @(negedge clk);
      start = 1'b1; is_signed = 1'b0; dividend = 32'd500; divisor = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort busy", {31'b0, busy}, 32'd0);
      chk("abort q", quotient, 32'd0);
      chk("abort r", remainder, 32'd0);
      chk("abort dbz", {31'b0, div_by_zero}, 32'd0);
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) dones++;
      end
      chk("abort no done", dones, 0);
      last_q = '0;
      last_r = '0;

      // Reset and start together: reset wins
      reset = 1'b1; start = 1'b1; dividend = 32'd9; divisor = 32'd3;
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("rst+start busy", {31'b0, busy}, 32'd0);

      run_div("post rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
